// File: rtl/frsim_mon_pkg.sv
// Shared definitions for FrSim edge monitors: record layout helpers.
package frsim_mon_pkg;

  // Flag bit offsets above the interval field of a record.
  localparam int unsigned REC_RISE  = 0;
  localparam int unsigned REC_FIRST = 1;

  function automatic int unsigned rec_w(input int unsigned cnt_w);
    return cnt_w + 2;
  endfunction

endpackage

// File: rtl/frsim_edge_monitor_if.sv
// Valid/ready event stream from an edge monitor to the host bridge.
interface frsim_edge_monitor_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic                                  ev_valid;
  logic                                  ev_ready;
  logic [frsim_mon_pkg::rec_w(CNT_W)-1:0] ev_data;

  modport master (output ev_valid, output ev_data, input ev_ready);
  modport slave  (input ev_valid, input ev_data, output ev_ready);

endinterface

// File: rtl/frsim_sync_fifo.sv
// Show-ahead synchronous FIFO; read data holds the last popped entry while empty.
module frsim_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne  = 1;
  localparam logic [AW:0]   LvlOne  = 1;
  localparam logic [AW:0]   LvlFull = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic [WIDTH-1:0] last_q;
  logic             push_en, pop_en;

  assign empty   = (level_q == '0);
  assign full    = (level_q == LvlFull);
  assign level   = level_q;
  assign pop_en  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_en = push && (!full || pop_en);
  assign rdata   = empty ? last_q : mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      last_q   <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + PtrOne;
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_q + PtrOne;
        last_q   <= mem_q[rd_ptr_q];
      end
      if (push_en && !pop_en) begin
        level_q <= level_q + LvlOne;
      end else if (pop_en && !push_en) begin
        level_q <= level_q - LvlOne;
      end
    end
  end

endmodule

// File: rtl/frsim_edge_monitor.sv
// Timestamps transitions of a toggling signal and queues {first, rising, interval} records.
module frsim_edge_monitor #(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    sig_in,
  frsim_edge_monitor_if.master    ev,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow,
  input  logic                    ovf_clr
);

  import frsim_mon_pkg::*;

  localparam int unsigned RW = rec_w(CNT_W);
  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic             prev_q, prev_d;
  logic             armed_q, armed_d;
  logic             first_q, first_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             overflow_q, overflow_d;
  logic             edge_ev, pop, full, empty, drop;
  logic [RW-1:0]    rec;

  assign cnt_inc = (cnt_q == CntMax) ? CntMax : cnt_q + CntOne;
  assign edge_ev = armed_q && en && (sig_in != prev_q);
  assign pop     = ev.ev_valid && ev.ev_ready;
  assign drop    = edge_ev && full && !pop;

  always_comb begin
    rec                     = '0;
    rec[CNT_W-1:0]          = cnt_inc;
    rec[CNT_W + REC_RISE]   = sig_in;
    rec[CNT_W + REC_FIRST]  = first_q;
  end

  always_comb begin
    prev_d  = prev_q;
    armed_d = armed_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    if (!en) begin
      armed_d = 1'b0;
      cnt_d   = '0;
    end else if (!armed_q) begin
      // Arming samples the current level so a stale prev never fakes an edge.
      prev_d  = sig_in;
      armed_d = 1'b1;
      cnt_d   = '0;
      first_d = 1'b1;
    end else if (edge_ev) begin
      prev_d  = sig_in;
      cnt_d   = '0;
      first_d = 1'b0;
    end else begin
      cnt_d   = cnt_inc;
    end
  end

  always_comb begin
    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 1'b0;
      armed_q    <= 1'b0;
      cnt_q      <= '0;
      first_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      armed_q    <= armed_d;
      cnt_q      <= cnt_d;
      first_q    <= first_d;
      overflow_q <= overflow_d;
    end
  end

  frsim_sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (edge_ev),
    .wdata (rec),
    .pop   (pop),
    .rdata (ev.ev_data),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign ev.ev_valid = !empty;
  assign overflow    = overflow_q;

endmodule
